i2c_subordinate: RTL and testbench

- I2C target (subordinate) endpoint: the downstream consumer on the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, delivers written bytes on a valid strobe, and requests bytes for master reads.
- Drives SDA open-drain (low or released) for ACK and read data. Used as a bus-level loopback target in master verification and as a register-port front end.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_bus_sync.sv | 65 ++++++
 rtl/i2c_subordinate.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_subordinate.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the subordinate endpoint and the bus master.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StWriteAck,
    StRead,
    StReadAck,
    StWaitStop
  } i2c_sub_state_t;

  function automatic logic addr_match(input logic [7:0]            addr_byte,
                                      input logic [I2C_ADDR_W-1:0] own_addr);
    return addr_byte[7:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus registered edge and START/STOP detection.
// Every event and level output lags the pin by three clk cycles.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise_d, scl_rise_q;
  logic       scl_fall_d, scl_fall_q;
  logic       start_d, start_q;
  logic       stop_d, stop_q;
  logic       scl_now, sda_now;

  assign scl_now = scl_sync_q[1];
  assign sda_now = sda_sync_q[1];

  always_comb begin
    scl_rise_d = scl_now & ~scl_prev_q;
    scl_fall_d = ~scl_now & scl_prev_q;
    // SCL must be high both before and after the SDA edge to count as a bus condition
    start_d    = scl_now & scl_prev_q & sda_prev_q & ~sda_now;
    stop_d     = scl_now & scl_prev_q & ~sda_prev_q & sda_now;
  end

  // Idle bus is high; reset to 1 so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_now;
      sda_prev_q <= sda_now;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_s     = scl_prev_q;
  assign sda_s     = sda_prev_q;
  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_subordinate.sv
// I2C target endpoint: fixed 7-bit address, byte write strobe, byte read request,
// open-drain SDA for ACK and read data. No clock stretching.
module i2c_subordinate
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] OWN_ADDR      = 7'h42,
  parameter int unsigned           MIN_CLK_RATIO = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       done
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_bus_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (SCL),
    .sda_i    (SDA),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_sub_state_t state_d, state_q;
  logic [2:0]     bit_cnt_d, bit_cnt_q;
  logic           byte_done_d, byte_done_q;
  logic [7:0]     shift_d, shift_q;
  logic           rw_d, rw_q;
  logic           ack_d, ack_q;
  logic           sda_oe_d, sda_oe_q;
  logic           busy_d, busy_q;
  logic           addressed_d, addressed_q;
  logic [7:0]     rx_data_d, rx_data_q;
  logic           rx_valid_d, rx_valid_q;
  logic           tx_req_d, tx_req_q;
  logic           done_d, done_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    done_d      = 1'b0;

    if (stop_det) begin
      // addressed_q outlives a NACK-driven busy drop, so done still marks the STOP
      // that closes a transaction this block answered.
      state_d     = StIdle;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = addressed_q;
      addressed_d = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      state_d     = StAddr;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;

        StAddr: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              rw_d        = shift_d[0];
              if (addr_match(shift_d, OWN_ADDR)) begin
                busy_d      = 1'b1;
                addressed_d = 1'b1;
                tx_req_d    = (shift_d[0] == I2C_RW_READ);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            if (busy_q) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q == I2C_RW_WRITE) begin
              state_d  = StWrite;
              sda_oe_d = 1'b0;
            end else begin
              state_d  = StRead;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
            end
          end
        end

        StWrite: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              rx_data_d   = shift_d;
              rx_valid_d  = 1'b1;
              ack_d       = rx_ready ? I2C_ACK : I2C_NACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall && byte_done_q) begin
            state_d     = StWriteAck;
            sda_oe_d    = (ack_q == I2C_ACK);
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
          end
        end

        StWriteAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (ack_q == I2C_ACK) begin
              state_d = StWrite;
            end else begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end
        end

        StRead: begin
          if (scl_rise) begin
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (scl_fall) begin
            if (byte_done_q) begin
              state_d     = StReadAck;
              sda_oe_d    = 1'b0;
              bit_cnt_d   = 3'd0;
              byte_done_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_d[7];
            end
          end
        end

        StReadAck: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              tx_req_d    = 1'b1;
              byte_done_d = 1'b1;
            end else begin
              state_d  = StWaitStop;
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
            end
          end else if (scl_fall && byte_done_q) begin
            state_d     = StRead;
            shift_d     = tx_data;
            sda_oe_d    = ~tx_data[7];
            byte_done_d = 1'b0;
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      ack_q       <= I2C_NACK;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      done_q      <= done_d;
    end
  end

  // sda_oe_q is cleared by the asynchronous reset, so SDA releases without a clock.
  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign done     = done_q;

  logic unused_sig;
  assign unused_sig = ^{scl_s, MIN_CLK_RATIO};

endmodule

// File: tb/tb_i2c_subordinate.sv
// Directed bench for i2c_subordinate: a bit-banged master drives SCL/SDA with a pull-up.
module tb_i2c_subordinate;

  localparam int unsigned CLK_HALF      = 5;
  localparam int unsigned Q             = 100;  // quarter SCL period, ns
  localparam int unsigned MIN_CLK_RATIO = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       scl      = 1'b1;
  logic       m_sda    = 1'b1;  // 1 = master releases SDA
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, done;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda ? 1'bz : 1'b0;

  always #(CLK_HALF) clk = ~clk;

  i2c_subordinate #(
    .OWN_ADDR     (7'h42),
    .MIN_CLK_RATIO(MIN_CLK_RATIO)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SCL     (scl),
    .SDA     (sda_bus),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy),
    .done    (done)
  );

  initial assert ((4 * Q) / (2 * CLK_HALF) >= MIN_CLK_RATIO)
    else $error("SCL period too short for MIN_CLK_RATIO");

  int unsigned rxv_cnt = 0, txr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (tx_req)   txr_cnt <= txr_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
  end

  int unsigned pass_cnt = 0, total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One SCL clock: drive (or release) SDA while low, sample mid-high.
  task automatic xfer_bit(input logic drive, output logic seen);
    m_sda = drive;
    #(Q); scl = 1'b1;
    #(Q); seen = sda_bus;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic start_cond();
    m_sda = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_sda = 1'b0;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_sda = 1'b1;
    #(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] data);
    logic [7:0] d;
    logic       s;
    for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
    tx_data = next_tx;
    xfer_bit(mack, s);
    data = d;
  endtask

  typedef struct packed {
    logic [7:0] addr_byte;
    logic [7:0] data;
    logic       rdy;
    logic       exp_aack;
    logic       exp_dack;
    logic [7:0] exp_rxv;
    logic [7:0] exp_rx;
    logic [7:0] exp_done;
  } wr_vec_t;

  wr_vec_t vecs[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, dk, s;
    logic [7:0] d;
    int unsigned r0, t0, d0;

    vecs[0] = '{8'h84, 8'hA5, 1'b1, 1'b0, 1'b0, 8'd1, 8'hA5, 8'd1};
    vecs[1] = '{8'h86, 8'h5A, 1'b1, 1'b1, 1'b1, 8'd0, 8'hA5, 8'd0};
    vecs[2] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 8'd0, 8'hA5, 8'd0};
    vecs[3] = '{8'h84, 8'h11, 1'b0, 1'b0, 1'b1, 8'd1, 8'h11, 8'd1};
    vecs[4] = '{8'h84, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 8'h00, 8'd1};
    vecs[5] = '{8'h84, 8'hFF, 1'b1, 1'b0, 1'b0, 8'd1, 8'hFF, 8'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sda", sda_bus, 1'b1);
    rst_n = 1'b1;
    #(Q);
    check("post_rst_busy", busy, 1'b0);

    // Single-byte writes from the table
    for (int i = 0; i < 6; i++) begin
      rx_ready = vecs[i].rdy;
      r0 = rxv_cnt;
      d0 = done_cnt;
      start_cond();
      send_byte(vecs[i].addr_byte, a);
      check($sformatf("v%0d_addr_ack", i), a, vecs[i].exp_aack);
      check($sformatf("v%0d_busy_mid", i), busy, !vecs[i].exp_aack);
      send_byte(vecs[i].data, dk);
      check($sformatf("v%0d_data_ack", i), dk, vecs[i].exp_dack);
      stop_cond();
      check($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - r0, vecs[i].exp_rxv);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_done_cnt", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
    end
    rx_ready = 1'b1;

    // Read two bytes: master ACKs the first, NACKs the second
    tx_data = 8'h3C;
    t0 = txr_cnt;
    d0 = done_cnt;
    start_cond();
    send_byte(8'h85, a);
    check("rd_addr_ack", a, 1'b0);
    check("rd_tx_req_1", txr_cnt - t0, 1);
    recv_byte(1'b0, 8'hC3, d);
    check("rd_byte1", d, 8'h3C);
    recv_byte(1'b1, 8'h00, d);
    check("rd_byte2", d, 8'hC3);
    check("rd_tx_req_2", txr_cnt - t0, 2);
    check("rd_sda_released", sda_bus, 1'b1);
    check("rd_busy_after_nack", busy, 1'b0);
    stop_cond();
    check("rd_done", done_cnt - d0, 1);

    // Data NACK, then a stray byte of SCL pulses before STOP
    rx_ready = 1'b0;
    start_cond();
    send_byte(8'h84, a);
    check("nk_addr_ack", a, 1'b0);
    send_byte(8'h11, dk);
    check("nk_data_nack", dk, 1'b1);
    check("nk_busy", busy, 1'b0);
    r0 = rxv_cnt;
    send_byte(8'h22, dk);
    check("nk_stray_rx_valid", rxv_cnt - r0, 0);
    check("nk_stray_ack", dk, 1'b1);
    stop_cond();
    rx_ready = 1'b1;

    // Repeated START: write address, then read address without STOP
    tx_data = 8'h5A;
    d0 = done_cnt;
    start_cond();
    send_byte(8'h84, a);
    check("rs_waddr_ack", a, 1'b0);
    start_cond();
    send_byte(8'h85, a);
    check("rs_raddr_ack", a, 1'b0);
    recv_byte(1'b1, 8'h00, d);
    check("rs_byte", d, 8'h5A);
    stop_cond();
    check("rs_done", done_cnt - d0, 1);

    // Asynchronous reset while the block drives a 0 read bit
    tx_data = 8'h00;
    start_cond();
    send_byte(8'h85, a);
    check("ar_addr_ack", a, 1'b0);
    #(Q); scl = 1'b1;
    #(Q);
    check("ar_driving_zero", sda_bus, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_sda_released", sda_bus, 1'b1);
    check("ar_busy", busy, 1'b0);
    check("ar_rx_data", rx_data, 8'h00);
    check("ar_tx_req", tx_req, 1'b0);
    check("ar_done", done, 1'b0);
    #(Q); scl = 1'b0;
    #(Q); rst_n = 1'b1;
    #(Q);
    r0 = rxv_cnt;
    d0 = done_cnt;
    send_byte(8'h84, a);
    check("ar_ignore_addr", a, 1'b1);
    send_byte(8'h33, dk);
    check("ar_ignore_rx_valid", rxv_cnt - r0, 0);
    check("ar_ignore_busy", busy, 1'b0);
    stop_cond();
    check("ar_no_done", done_cnt - d0, 0);
    start_cond();
    send_byte(8'h84, a);
    check("ar_next_addr_ack", a, 1'b0);
    send_byte(8'h66, dk);
    check("ar_next_data_ack", dk, 1'b0);
    stop_cond();
    check("ar_next_rx_data", rx_data, 8'h66);
    xfer_bit(1'b1, s);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
